seg_mmio_ctrl: RTL and testbench
================================

// Module: seg_mmio_ctrl
// PURPOSE
//  CPU-facing register slave that feeds the 7-segment display driver (display_seg).
//  Holds the 32-bit hex value shown on 8 digits, plus enable/blink control.
//  Sits between the SoC peripheral crossbar and display_seg:
//   disp_val -> display_seg.s; disp_on gates the anode enables downstream.
// PARAMETERS
//  ADDR_W        4               offset bits decoded; addr[1:0] ignored (word regs)
//  DATA_RST      32'h0000_0000   reset value of DATA register
//  BLINK_DIV_RST 32'd25_000_000  reset value of BLINK_DIV (half-period in clk cycles)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       slave can accept request
//  req_we     in   1       1=write, 0=read
//  req_addr   in   ADDR_W  byte offset
//  req_wdata  in   32      write data
//  req_wstrb  in   4       byte-lane write enables
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       master accepts response
//  rsp_rdata  out  32      read data (0 for writes/errors)
//  rsp_err    out  1       1 = unmapped offset
//  disp_val   out  32      value to display_seg.s
//  disp_on    out  1       1 = digits lit
// BEHAVIOUR
//  Register map (offset):
//   0x0 DATA      rw  32b, byte-strobed; reset DATA_RST
//   0x4 CTRL      rw  bit0 EN (reset 1), bit1 BLINK (reset 0); lane0 only; other bits read 0
//   0x8 BLINK_DIV rw  32b, byte-strobed; reset BLINK_DIV_RST
//   0xC STATUS    ro  bit0 phase, [31:16] wcnt; writes ignored, rsp_err=0
//   other         rsp_err=1, rdata=0, no side effect
//  FSM IDLE/RESP. IDLE: req_ready=1, rsp_valid=0. Accept on req_valid&req_ready ->
//   write committed at that edge, read data latched at that edge (pre-write value
//   irrelevant: no same-cycle write), go RESP. RESP: req_ready=0, rsp_valid=1,
//   outputs stable until rsp_ready=1 -> IDLE. Max 1 transaction per 2 cycles.
//  wcnt: +1 per accepted write to DATA with any strobe set; wraps 16'hFFFF->0.
//  Blink timer: when BLINK=0: cnt held = BLINK_DIV, phase=1. When BLINK=1: cnt
//   decrements each cycle; at cnt==0 reload BLINK_DIV and toggle phase.
//   BLINK_DIV=0 -> phase toggles every cycle. Write to BLINK_DIV reloads cnt with
//   new value next cycle, phase unchanged. BLINK 0->1: counting starts, phase=1.
//  disp_val = DATA (registered, updates the cycle after write accept).
//  disp_on  = EN & phase (combinational from regs).
//  Reset (any time, incl. mid-transaction): FSM=IDLE, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, req_ready=1 after deassert, pending response discarded;
//   DATA=DATA_RST, EN=1, BLINK=0, BLINK_DIV=BLINK_DIV_RST, wcnt=0, phase=1.
//   Outputs after reset: disp_val=DATA_RST, disp_on=1.
// STRUCTURE
//  Shared package seg_pkg: register offsets, CTRL bit indices (CTRL_EN, CTRL_BLINK),
//   FSM state enum {S_IDLE,S_RESP}.
//  Sub-module seg_blink_timer (div, en, reload -> phase); rest flat in this file.
// TESTING
//  Reset release -> disp_val=0, disp_on=1, req_ready=1, rsp_valid=0, STATUS reads 0x1.
//  Write DATA=0x1234_ABCD strobe 4'hF -> rsp 1 cycle later err=0; disp_val=0x1234ABCD; STATUS[31:16]=1.
//  Write DATA=0xFFFF_FFFF strobe 4'b0100 -> DATA=0x12FF_ABCD; read 0x10 -> err=1, rdata=0.
//  Hold rsp_ready=0 5 cycles -> rsp_valid/rdata stable, req_ready=0, new req not accepted.
//  BLINK_DIV=3, CTRL=0x3 -> disp_on toggles every 4 cycles; CTRL=0x1 -> disp_on=1 steady.
//  Assert rst while in RESP -> rsp_valid=0 immediately; all regs at reset values.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment MMIO controller: register offsets,
// CTRL bit positions and the request/response FSM states.
package seg_pkg;

  localparam int OFF_DATA   = 'h0;
  localparam int OFF_CTRL   = 'h4;
  localparam int OFF_DIV    = 'h8;
  localparam int OFF_STATUS = 'hC;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLINK = 1;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

endpackage

// File: rtl/seg_blink_timer.sv
// Blink phase generator: phase toggles every (div + 1) cycles while en is set,
// and is held high with the counter parked at div while en is clear.
module seg_blink_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] div,
  input  logic        en,
  input  logic        reload,
  output logic        phase
);

  logic [31:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!en) begin
      cnt   <= div;
      phase <= 1'b1;
    end else if (reload) begin
      cnt   <= div;
    end else if (cnt == '0) begin
      cnt   <= div;
      phase <= ~phase;
    end else begin
      cnt   <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/seg_mmio_ctrl.sv
// CPU-facing register slave for the display_seg driver: holds the displayed
// value, enable/blink control and the blink divider behind a valid/ready port.
module seg_mmio_ctrl
  import seg_pkg::*;
#(
  parameter int          ADDR_W        = 4,
  parameter logic [31:0] DATA_RST      = 32'h0000_0000,
  parameter logic [31:0] BLINK_DIV_RST = 32'd25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       disp_val,
  output logic              disp_on
);

  state_t            state_q, state_d;
  logic [31:0]       data_q, div_q, rd_data;
  logic              en_q, blink_q, div_wr_q, phase;
  logic [15:0]       wcnt_q;
  logic [ADDR_W-1:0] word_addr;
  logic              sel_data, sel_ctrl, sel_div, sel_status, mapped;
  logic              accept, wr;

  assign word_addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign sel_data   = (word_addr == ADDR_W'(OFF_DATA));
  assign sel_ctrl   = (word_addr == ADDR_W'(OFF_CTRL));
  assign sel_div    = (word_addr == ADDR_W'(OFF_DIV));
  assign sel_status = (word_addr == ADDR_W'(OFF_STATUS));
  assign mapped     = sel_data | sel_ctrl | sel_div | sel_status;
  assign accept     = req_valid & req_ready;
  assign wr         = accept & req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (sel_data) rd_data = data_q;
    if (sel_ctrl) begin
      rd_data[CTRL_EN]    = en_q;
      rd_data[CTRL_BLINK] = blink_q;
    end
    if (sel_div)    rd_data = div_q;
    if (sel_status) rd_data = {wcnt_q, 15'd0, phase};
  end

  // Response is captured at accept and held untouched while RESP waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= req_we ? 32'd0 : rd_data;
      rsp_err   <= ~mapped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= DATA_RST;
      div_q    <= BLINK_DIV_RST;
      en_q     <= 1'b1;
      blink_q  <= 1'b0;
      wcnt_q   <= '0;
      div_wr_q <= 1'b0;
    end else begin
      div_wr_q <= wr & sel_div;
      if (wr && sel_data) begin
        for (int i = 0; i < 4; i++)
          if (req_wstrb[i]) data_q[8*i +: 8] <= req_wdata[8*i +: 8];
        if (|req_wstrb) wcnt_q <= wcnt_q + 16'd1;
      end
      if (wr && sel_ctrl && req_wstrb[0]) begin
        en_q    <= req_wdata[CTRL_EN];
        blink_q <= req_wdata[CTRL_BLINK];
      end
      if (wr && sel_div) begin
        for (int i = 0; i < 4; i++)
          if (req_wstrb[i]) div_q[8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Reload is delayed a cycle so the timer picks up the freshly written divider.
  seg_blink_timer u_blink (
    .clk    (clk),
    .rst    (rst),
    .div    (div_q),
    .en     (blink_q),
    .reload (div_wr_q),
    .phase  (phase)
  );

  assign disp_val = data_q;
  assign disp_on  = en_q & phase;

endmodule

// File: tb/tb_seg_mmio_ctrl.sv
// Self-checking bench for seg_mmio_ctrl: scoreboarded register accesses plus
// directed blink, backpressure and mid-transaction reset scenarios.
module tb_seg_mmio_ctrl;

  localparam int AW    = 8;
  localparam int BOUND = 20;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          req_ready, rsp_valid, rsp_err, disp_on;
  logic [31:0]   rsp_rdata, disp_val;

  rsp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  seg_mmio_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .disp_val  (disp_val),
    .disp_on   (disp_on)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // One transaction: expected response is queued when the request is driven
  // and popped when rsp_valid appears. lat = extra cycles after accept.
  task automatic bus(input string name, input logic we, input logic [AW-1:0] addr,
                     input logic [31:0] wd, input logic [3:0] st,
                     input logic [31:0] exp_rd, input logic exp_err, output int lat);
    rsp_t e;
    int   n;
    sb.push_back(rsp_t'{exp_rd, exp_err});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
    n = 0;
    while (!req_ready && n < BOUND) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < BOUND) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
      $display("FAIL %s: valid=%b rdata=%h err=%b, required valid=1 rdata=%h err=%b",
               name, rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    total++;
    if (disp_val !== 32'h0 || disp_on !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset_outputs: disp_val=%h disp_on=%b req_ready=%b rsp_valid=%b, required 0/1/1/0",
               disp_val, disp_on, req_ready, rsp_valid);
    else passed++;
    bus("reset_status", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0000_0001, 1'b0, lat);
    bus("reset_ctrl",   1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_0001, 1'b0, lat);
    bus("reset_div",    1'b0, 8'h08, 32'h0, 4'h0, 32'd25_000_000, 1'b0, lat);
  endtask

  task automatic test_write_data();
    int lat;
    bus("wr_data_full", 1'b1, 8'h00, 32'h1234_ABCD, 4'hF, 32'h0, 1'b0, lat);
    total++;
    if (lat !== 0 || disp_val !== 32'h1234_ABCD)
      $display("FAIL wr_data_effect: latency=%0d disp_val=%h, required latency=0 disp_val=1234abcd",
               lat, disp_val);
    else passed++;
    bus("status_wcnt1", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0001_0001, 1'b0, lat);
    bus("wr_data_lane2", 1'b1, 8'h00, 32'hFFFF_FFFF, 4'b0100, 32'h0, 1'b0, lat);
    bus("rd_data_lane2", 1'b0, 8'h00, 32'h0, 4'h0, 32'h12FF_ABCD, 1'b0, lat);
    bus("wr_data_nostrb", 1'b1, 8'h00, 32'h0, 4'h0, 32'h0, 1'b0, lat);
    bus("rd_addr_low_ign", 1'b0, 8'h03, 32'h0, 4'h0, 32'h12FF_ABCD, 1'b0, lat);
    bus("status_wcnt2", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0002_0001, 1'b0, lat);
  endtask

  task automatic test_decode();
    int lat;
    bus("rd_unmapped", 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b1, lat);
    bus("wr_unmapped", 1'b1, 8'h14, 32'hAAAA_5555, 4'hF, 32'h0, 1'b1, lat);
    bus("wr_status",   1'b1, 8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, lat);
    bus("rd_data_kept", 1'b0, 8'h00, 32'h0, 4'h0, 32'h12FF_ABCD, 1'b0, lat);
    bus("status_kept", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0002_0001, 1'b0, lat);
    bus("wr_ctrl_off", 1'b1, 8'h04, 32'hFFFF_FFFC, 4'hF, 32'h0, 1'b0, lat);
    total++;
    if (disp_on !== 1'b0)
      $display("FAIL disp_off: disp_on=%b, required 0", disp_on);
    else passed++;
    bus("wr_ctrl_lane1", 1'b1, 8'h04, 32'h0000_0101, 4'b1110, 32'h0, 1'b0, lat);
    bus("rd_ctrl_off", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0, lat);
    bus("wr_ctrl_on", 1'b1, 8'h04, 32'hFFFF_FFFD, 4'h1, 32'h0, 1'b0, lat);
    bus("rd_ctrl_bits", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_0001, 1'b0, lat);
  endtask

  task automatic test_hold();
    rsp_t e;
    int   lat;
    sb.push_back(rsp_t'{32'h12FF_ABCD, 1'b0});
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_wstrb = 4'h0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0)
        $display("FAIL hold_cycle%0d: valid=%b rdata=%h err=%b req_ready=%b, required 1/%h/%b/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
      else passed++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL hold_release: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
    else passed++;
    bus("hold_no_write", 1'b0, 8'h00, 32'h0, 4'h0, 32'h12FF_ABCD, 1'b0, lat);
    bus("hold_wcnt", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0002_0001, 1'b0, lat);
  endtask

  task automatic test_blink();
    int   lat, last_t, toggles, bad;
    logic prev;
    logic [31:0] divs [2];
    divs[0] = 32'd3;
    divs[1] = 32'd0;
    for (int d = 0; d < 2; d++) begin
      bus("wr_div", 1'b1, 8'h08, divs[d], 4'hF, 32'h0, 1'b0, lat);
      bus("wr_ctrl_blink", 1'b1, 8'h04, 32'h3, 4'h1, 32'h0, 1'b0, lat);
      @(negedge clk);
      prev = disp_on; last_t = -1; toggles = 0; bad = 0;
      for (int t = 1; t <= 24; t++) begin
        @(negedge clk);
        if (disp_on !== prev) begin
          if (last_t >= 0 && (t - last_t) != int'(divs[d]) + 1) bad++;
          last_t = t; toggles++;
          prev = disp_on;
        end
      end
      total++;
      if (bad != 0 || toggles < 24 / (int'(divs[d]) + 1) - 1)
        $display("FAIL blink_div%0d: toggles=%0d bad_intervals=%0d, required interval %0d with >=%0d toggles",
                 divs[d], toggles, bad, divs[d] + 1, 24 / (int'(divs[d]) + 1) - 1);
      else passed++;
      bus("wr_ctrl_steady", 1'b1, 8'h04, 32'h1, 4'h1, 32'h0, 1'b0, lat);
      bad = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (disp_on !== 1'b1) bad++;
      end
      total++;
      if (bad != 0)
        $display("FAIL steady_div%0d: disp_on low in %0d cycles, required 0", divs[d], bad);
      else passed++;
    end
    bus("rd_div", 1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b0, lat);
    bus("status_phase", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0002_0001, 1'b0, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    bus("pre_div", 1'b1, 8'h08, 32'h7, 4'hF, 32'h0, 1'b0, lat);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_wstrb = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12FF_ABCD)
      $display("FAIL mid_resp: rsp_valid=%b rdata=%h, required 1/12ffabcd", rsp_valid, rsp_rdata);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        disp_val !== 32'h0 || disp_on !== 1'b1)
      $display("FAIL mid_reset: valid=%b rdata=%h err=%b disp_val=%h disp_on=%b, required 0/0/0/0/1",
               rsp_valid, rsp_rdata, rsp_err, disp_val, disp_on);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL post_reset: req_ready=%b rsp_valid=%b, required 1/0", req_ready, rsp_valid);
    else passed++;
    bus("post_data",   1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 1'b0, lat);
    bus("post_ctrl",   1'b0, 8'h04, 32'h0, 4'h0, 32'h1, 1'b0, lat);
    bus("post_div",    1'b0, 8'h08, 32'h0, 4'h0, 32'd25_000_000, 1'b0, lat);
    bus("post_status", 1'b0, 8'h0C, 32'h0, 4'h0, 32'h1, 1'b0, lat);
  endtask

  initial begin
    #22 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write_data();
    test_decode();
    test_hold();
    test_blink();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
